// File: rtl/multi_lane_clause_selector_if.sv
// multi_lane_clause_selector_if
// Request/result bus of the multi-lane clause selector.
//   Request side : req_valid_i, req_ready_o, count_i (m per lane), random_i (32-bit word per lane)
//   Result side  : sel_valid_o, sel_ready_i, sel_o (index per lane), sel_empty_o (m was 0)
// The slave modport is the selector's view; the master modport is the surrounding logic's view.
interface multi_lane_clause_selector_if #(
    parameter int NUM_LANES    = 4,
    parameter int BUFFER_DEPTH = 2048
);
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int CW = AW + 1;

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [NUM_LANES*CW-1:0]   count_i;
    logic [NUM_LANES*32-1:0]   random_i;
    logic                      sel_valid_o;
    logic                      sel_ready_i;
    logic [NUM_LANES*AW-1:0]   sel_o;
    logic [NUM_LANES-1:0]      sel_empty_o;

    modport slave (
        input  req_valid_i, count_i, random_i, sel_ready_i,
        output req_ready_o, sel_valid_o, sel_o, sel_empty_o
    );

    modport master (
        output req_valid_i, count_i, random_i, sel_ready_i,
        input  req_ready_o, sel_valid_o, sel_o, sel_empty_o
    );
endinterface

// File: rtl/multi_lane_clause_selector.sv
// multi_lane_clause_selector
// Picks one clause index per lane each cycle as sel = R mod m, where R is a field of the
// lane's random word and m is the lane's unsat buffer count. A loadable reciprocal table
// (entry[m] = floor((2^M_TABLE_WIDTH-1)/m)) gives a quotient estimate that is at most one
// too small; a single correction step makes the remainder exact.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   setup           : table load mode (entering it from RUN flushes the pipeline)
//   mt_we_i         : table write strobe, honoured while setup=1
//   write_addr_i    : table write address (0..BUFFER_DEPTH)
//   mt_data_i       : table write data
//   ready           : table loaded and block in RUN
//   bus             : request/result handshake bus (slave modport)
// Optional: define CLAUSE_SEL_STATS_EN to add stat_sel_cnt_o (output handshakes) and
// stat_empty_cnt_o (sum of empty lanes over handshakes), both wrapping 32-bit counters.
module multi_lane_clause_selector #(
    parameter int BUFFER_DEPTH     = 2048,
    parameter int NUM_LANES        = 4,
    parameter int RANDOM_OFFSET    = 10,
    parameter int RANDOM_NUM_WIDTH = 18,
    parameter int M_TABLE_WIDTH    = 32,
    localparam int AW = $clog2(BUFFER_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     setup,
    input  logic                     mt_we_i,
    input  logic [CW-1:0]            write_addr_i,
    input  logic [M_TABLE_WIDTH-1:0] mt_data_i,
    output logic                     ready,
    multi_lane_clause_selector_if.slave bus
`ifdef CLAUSE_SEL_STATS_EN
    ,
    output logic [31:0]              stat_sel_cnt_o,
    output logic [31:0]              stat_empty_cnt_o
`endif
);

    localparam int RW  = RANDOM_NUM_WIDTH;
    localparam int MTW = M_TABLE_WIDTH;
    localparam int PW  = RW + MTW;

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t state_q;
    logic   loaded_q;
    logic   setup_q;
    logic   ready_q;

    logic [MTW-1:0] table_mem [0:BUFFER_DEPTH];

    logic en;
    logic accept;
    logic flush;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [NUM_LANES-1:0][CW-1:0]  m1_q, m1_d, m2_q, m2_d;
    logic [NUM_LANES-1:0][RW-1:0]  r1_q, r1_d, r2_q, r2_d, q2_q, q2_d;
    logic [NUM_LANES-1:0][MTW-1:0] e1_q, e1_d;
    logic [NUM_LANES-1:0][AW-1:0]  sel3_q, sel3_d;
    logic [NUM_LANES-1:0]          empty3_q, empty3_d;

    logic [NUM_LANES-1:0][PW-1:0]    prod_w;
    logic [NUM_LANES-1:0][RW-1:0]    q_w;
    logic [NUM_LANES-1:0][RW+CW-1:0] qm_w;
    logic [NUM_LANES-1:0][RW:0]      rem_w;
    logic [NUM_LANES-1:0][RW:0]      mext_w;
    logic [NUM_LANES-1:0][RW:0]      fix_w;
    logic [NUM_LANES-1:0]            unused_lane;
    logic                            unused_random;

    // A single advance enable keeps all three stages in lockstep under backpressure.
    assign en              = !v3_q || bus.sel_ready_i;
    assign bus.req_ready_o = en && (state_q == ST_RUN) && !reset;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign flush           = (state_q == ST_RUN) && setup;
    assign ready           = ready_q;

    assign bus.sel_valid_o = v3_q;
    assign bus.sel_o       = sel3_q;
    assign bus.sel_empty_o = empty3_q;

    // Load/run control. loaded_q survives reset so a reset after loading returns to RUN;
    // leaving LOAD is triggered by the falling edge of setup, not by setup being low.
    always_ff @(posedge clk) begin
        setup_q <= setup;
        if (reset) begin
            state_q <= loaded_q ? ST_RUN : ST_LOAD;
            ready_q <= loaded_q;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (setup_q && !setup) begin
                        loaded_q <= 1'b1;
                        state_q  <= ST_RUN;
                        ready_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (setup) begin
                        state_q <= ST_LOAD;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Reciprocal table; not reset so its contents persist across resets.
    always_ff @(posedge clk) begin
        if (setup && mt_we_i) begin
            table_mem[write_addr_i] <= mt_data_i;
        end
    end

    // Per-lane arithmetic: quotient estimate in S2, remainder with one correction in S3.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign prod_w[k] = {{MTW{1'b0}}, r1_q[k]} * {{RW{1'b0}}, e1_q[k]};
        assign q_w[k]    = prod_w[k][PW-1:MTW];
        assign qm_w[k]   = {{CW{1'b0}}, q2_q[k]} * {{RW{1'b0}}, m2_q[k]};
        assign rem_w[k]  = {1'b0, r2_q[k]} - qm_w[k][RW:0];
        assign mext_w[k] = {{(RW+1-CW){1'b0}}, m2_q[k]};
        assign fix_w[k]  = (rem_w[k] >= mext_w[k]) ? (rem_w[k] - mext_w[k]) : rem_w[k];
        // Low product bits, high q*m bits and high remainder bits are dropped by design.
        assign unused_lane[k] = ^{prod_w[k][MTW-1:0], qm_w[k][RW+CW-1:RW+1], fix_w[k][RW:AW]};
    end
    assign unused_random = ^bus.random_i;

    // Next-state for pipeline valids and per-lane stage data.
    always_comb begin
        v1_d     = v1_q;
        v2_d     = v2_q;
        v3_d     = v3_q;
        m1_d     = m1_q;
        r1_d     = r1_q;
        e1_d     = e1_q;
        m2_d     = m2_q;
        r2_d     = r2_q;
        q2_d     = q2_q;
        sel3_d   = sel3_q;
        empty3_d = empty3_q;
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end else if (en) begin
            v1_d = accept;
            v2_d = v1_q;
            v3_d = v2_q;
        end
        if (en) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (accept) begin
                    m1_d[k] = bus.count_i[k*CW +: CW];
                    r1_d[k] = bus.random_i[k*32 + RANDOM_OFFSET +: RW];
                    e1_d[k] = table_mem[bus.count_i[k*CW +: CW]];
                end
                if (v1_q) begin
                    m2_d[k] = m1_q[k];
                    r2_d[k] = r1_q[k];
                    q2_d[k] = q_w[k];
                end
                if (v2_q) begin
                    sel3_d[k]   = (m2_q[k] == '0) ? '0 : fix_w[k][AW-1:0];
                    empty3_d[k] = (m2_q[k] == '0);
                end
            end
        end
    end

    // Control flops of the pipeline; these are the only ones with a reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            sel3_q   <= '0;
            empty3_q <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            sel3_q   <= sel3_d;
            empty3_q <= empty3_d;
        end
    end

    // Stage data is qualified by the valids, so it needs no reset.
    always_ff @(posedge clk) begin
        m1_q <= m1_d;
        r1_q <= r1_d;
        e1_q <= e1_d;
        m2_q <= m2_d;
        r2_q <= r2_d;
        q2_q <= q2_d;
    end

`ifdef CLAUSE_SEL_STATS_EN
    logic [31:0] stat_sel_cnt_q, stat_sel_cnt_d;
    logic [31:0] stat_empty_cnt_q, stat_empty_cnt_d;

    // Statistics advance on each output handshake and wrap naturally.
    always_comb begin
        stat_sel_cnt_d   = stat_sel_cnt_q;
        stat_empty_cnt_d = stat_empty_cnt_q;
        if (v3_q && bus.sel_ready_i) begin
            stat_sel_cnt_d   = stat_sel_cnt_q + 32'd1;
            stat_empty_cnt_d = stat_empty_cnt_q + 32'($countones(empty3_q));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_sel_cnt_q   <= '0;
            stat_empty_cnt_q <= '0;
        end else begin
            stat_sel_cnt_q   <= stat_sel_cnt_d;
            stat_empty_cnt_q <= stat_empty_cnt_d;
        end
    end

    assign stat_sel_cnt_o   = stat_sel_cnt_q;
    assign stat_empty_cnt_o = stat_empty_cnt_q;
`endif

endmodule

// File: tb/tb_multi_lane_clause_selector.sv
// tb_multi_lane_clause_selector
// Directed bench for multi_lane_clause_selector: load, latency, lane corner cases,
// back-to-back streaming, backpressure, reset with retained table and setup flush.
module tb_multi_lane_clause_selector;
    localparam int BUFFER_DEPTH = 2048;
    localparam int NUM_LANES    = 4;
    localparam int AW           = 11;
    localparam int CW           = 12;
    localparam int RW           = 18;
    localparam int RO           = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          setup;
    logic          mt_we_i;
    logic [CW-1:0] write_addr_i;
    logic [31:0]   mt_data_i;
    logic          ready;

    int checks = 0;
    int errors = 0;

    logic [4*AW-1:0] expSelQ[$];
    logic [3:0]      expEmptyQ[$];

    multi_lane_clause_selector_if #(.NUM_LANES(NUM_LANES), .BUFFER_DEPTH(BUFFER_DEPTH)) bus_if();

`ifdef CLAUSE_SEL_STATS_EN
    logic [31:0] statSelCnt;
    logic [31:0] statEmptyCnt;
`endif

    multi_lane_clause_selector dut (
        .clk          (clk),
        .reset        (reset),
        .setup        (setup),
        .mt_we_i      (mt_we_i),
        .write_addr_i (write_addr_i),
        .mt_data_i    (mt_data_i),
        .ready        (ready),
        .bus          (bus_if)
`ifdef CLAUSE_SEL_STATS_EN
        ,
        .stat_sel_cnt_o   (statSelCnt),
        .stat_empty_cnt_o (statEmptyCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m0, input int m1, input int m2, input int m3,
                                 input int r0, input int r1, input int r2, input int r3);
        bus_if.count_i     = {CW'(m3), CW'(m2), CW'(m1), CW'(m0)};
        bus_if.random_i    = {32'(r3 << RO), 32'(r2 << RO), 32'(r1 << RO), 32'(r0 << RO)};
        bus_if.req_valid_i = 1'b1;
    endtask

    function automatic logic [4*AW-1:0] packSel(input int s0, input int s1, input int s2, input int s3);
        return {AW'(s3), AW'(s2), AW'(s1), AW'(s0)};
    endfunction

    initial begin
        logic [4*AW-1:0] es;
        logic [3:0]      ee;
        logic [31:0]     word;
        int              mv;
        int              rv;
        int              received;

        reset               = 1'b1;
        setup               = 1'b0;
        mt_we_i             = 1'b0;
        write_addr_i        = '0;
        mt_data_i           = '0;
        bus_if.req_valid_i  = 1'b0;
        bus_if.count_i      = '0;
        bus_if.random_i     = '0;
        bus_if.sel_ready_i  = 1'b1;

        // Power-up reset without any table load stays in LOAD
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("powerup_ready", 64'(ready), 64'd0);
        checkOutput("powerup_req_ready", 64'(bus_if.req_ready_o), 64'd0);
        checkOutput("powerup_sel_valid", 64'(bus_if.sel_valid_o), 64'd0);
        checkOutput("powerup_sel", 64'(bus_if.sel_o), 64'd0);
        checkOutput("powerup_empty", 64'(bus_if.sel_empty_o), 64'd0);

        // Load the full reciprocal table
        setup   = 1'b1;
        mt_we_i = 1'b1;
        for (int a = 0; a <= BUFFER_DEPTH; a++) begin
            write_addr_i = CW'(a);
            mt_data_i    = (a == 0) ? 32'd0 : 32'(64'hFFFF_FFFF / 64'(a));
            tick();
        end
        mt_we_i = 1'b0;
        checkOutput("load_ready_low", 64'(ready), 64'd0);
        setup = 1'b0;
        tick();
        checkOutput("run_ready", 64'(ready), 64'd1);
        checkOutput("run_req_ready", 64'(bus_if.req_ready_o), 64'd1);

        // Latency: m=7, R=12345 -> 4, visible 3 cycles after acceptance
        applyStimulus(7, 1, 1, 1, 12345, 0, 0, 0);
        tick();
        bus_if.req_valid_i = 1'b0;
        checkOutput("lat_c1_valid", 64'(bus_if.sel_valid_o), 64'd0);
        tick();
        checkOutput("lat_c2_valid", 64'(bus_if.sel_valid_o), 64'd0);
        tick();
        checkOutput("lat_c3_valid", 64'(bus_if.sel_valid_o), 64'd1);
        checkOutput("lat_sel", 64'(bus_if.sel_o), 64'(packSel(4, 0, 0, 0)));
        checkOutput("lat_empty", 64'(bus_if.sel_empty_o), 64'd0);
        tick();
        checkOutput("lat_drained", 64'(bus_if.sel_valid_o), 64'd0);

        // Lane corner cases: m = 1, 10, BUFFER_DEPTH, 0
        applyStimulus(1, 10, 2048, 0, 99, 12345, 262143, 5);
        tick();
        bus_if.req_valid_i = 1'b0;
        tick();
        tick();
        checkOutput("corner_valid", 64'(bus_if.sel_valid_o), 64'd1);
        checkOutput("corner_sel", 64'(bus_if.sel_o), 64'(packSel(0, 5, 2047, 0)));
        checkOutput("corner_empty", 64'(bus_if.sel_empty_o), 64'(4'b1000));
        tick();

        // Back-to-back stream of 30 random requests, one result per cycle
        received = 0;
        for (int i = 0; i < 33; i++) begin
            if (i < 30) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    mv   = int'($urandom_range(0, BUFFER_DEPTH));
                    rv   = int'($urandom_range(0, (1 << RW) - 1));
                    word = $urandom;
                    word[RO +: RW] = rv[RW-1:0];
                    bus_if.count_i[k*CW +: CW]  = CW'(mv);
                    bus_if.random_i[k*32 +: 32] = word;
                    es[k*AW +: AW] = (mv == 0) ? AW'(0) : AW'(rv % mv);
                    ee[k]          = (mv == 0);
                end
                expSelQ.push_back(es);
                expEmptyQ.push_back(ee);
                bus_if.req_valid_i = 1'b1;
            end else begin
                bus_if.req_valid_i = 1'b0;
            end
            tick();
            if (bus_if.sel_valid_o) begin
                checkOutput("stream_pending", 64'(expSelQ.size() != 0), 64'd1);
                if (expSelQ.size() != 0) begin
                    es = expSelQ.pop_front();
                    ee = expEmptyQ.pop_front();
                    checkOutput("stream_sel", 64'(bus_if.sel_o), 64'(es));
                    checkOutput("stream_empty", 64'(bus_if.sel_empty_o), 64'(ee));
                    received++;
                end
            end
        end
        checkOutput("stream_count", 64'(received), 64'd30);

        // Backpressure: fill pipe with A,B,C while downstream stalls, D waits
        bus_if.sel_ready_i = 1'b0;
        applyStimulus(7, 3, 5, 100, 12345, 10, 7, 1000);
        tick();
        applyStimulus(9, 11, 13, 17, 100, 100, 100, 100);
        tick();
        applyStimulus(2048, 1000, 6, 1, 4101, 262143, 262143, 1);
        tick();
        applyStimulus(0, 2, 4, 8, 77, 77, 77, 77);
        checkOutput("bp_full_valid", 64'(bus_if.sel_valid_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_req_ready", 64'(bus_if.req_ready_o), 64'd0);
            checkOutput("bp_sel_hold", 64'(bus_if.sel_o), 64'(packSel(4, 1, 2, 0)));
            tick();
        end
        bus_if.sel_ready_i = 1'b1;
        #1;
        checkOutput("bp_release_req_ready", 64'(bus_if.req_ready_o), 64'd1);
        checkOutput("bp_sel_a", 64'(bus_if.sel_o), 64'(packSel(4, 1, 2, 0)));
        tick();
        bus_if.req_valid_i = 1'b0;
        checkOutput("bp_sel_b", 64'(bus_if.sel_o), 64'(packSel(1, 1, 9, 15)));
        tick();
        checkOutput("bp_sel_c", 64'(bus_if.sel_o), 64'(packSel(5, 143, 3, 0)));
        tick();
        checkOutput("bp_sel_d", 64'(bus_if.sel_o), 64'(packSel(0, 1, 1, 5)));
        checkOutput("bp_empty_d", 64'(bus_if.sel_empty_o), 64'(4'b0001));
        tick();
        checkOutput("bp_drained", 64'(bus_if.sel_valid_o), 64'd0);

        // Reset mid-stream keeps the table and returns straight to RUN
        applyStimulus(9, 11, 13, 17, 100, 100, 100, 100);
        tick();
        tick();
        tick();
        checkOutput("rst_pre_valid", 64'(bus_if.sel_valid_o), 64'd1);
        reset              = 1'b1;
        bus_if.req_valid_i = 1'b0;
        tick();
        checkOutput("rst_sel_valid", 64'(bus_if.sel_valid_o), 64'd0);
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_req_ready", 64'(bus_if.req_ready_o), 64'd0);
        checkOutput("rst_sel", 64'(bus_if.sel_o), 64'd0);
        reset = 1'b0;
        tick();
        checkOutput("rst_after_ready", 64'(ready), 64'd1);
        applyStimulus(7, 1, 1, 1, 12345, 0, 0, 0);
        tick();
        bus_if.req_valid_i = 1'b0;
        tick();
        tick();
        checkOutput("rst_redo_valid", 64'(bus_if.sel_valid_o), 64'd1);
        checkOutput("rst_redo_sel", 64'(bus_if.sel_o), 64'(packSel(4, 0, 0, 0)));
        tick();

        // Raising setup in RUN flushes the pipe and holds ready low until setup falls
        applyStimulus(9, 11, 13, 17, 100, 100, 100, 100);
        tick();
        tick();
        tick();
        checkOutput("flush_pre_valid", 64'(bus_if.sel_valid_o), 64'd1);
        setup              = 1'b1;
        bus_if.req_valid_i = 1'b0;
        tick();
        checkOutput("flush_sel_valid", 64'(bus_if.sel_valid_o), 64'd0);
        checkOutput("flush_ready", 64'(ready), 64'd0);
        checkOutput("flush_req_ready", 64'(bus_if.req_ready_o), 64'd0);
        tick();
        tick();
        checkOutput("flush_still_empty", 64'(bus_if.sel_valid_o), 64'd0);
        checkOutput("flush_hold_ready", 64'(ready), 64'd0);
        setup = 1'b0;
        tick();
        checkOutput("flush_back_ready", 64'(ready), 64'd1);
        applyStimulus(7, 3, 5, 100, 12345, 10, 7, 1000);
        tick();
        bus_if.req_valid_i = 1'b0;
        tick();
        tick();
        checkOutput("flush_redo_valid", 64'(bus_if.sel_valid_o), 64'd1);
        checkOutput("flush_redo_sel", 64'(bus_if.sel_o), 64'(packSel(4, 1, 2, 0)));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_lane_clause_selector.md
Name: multi_lane_clause_selector

Overview:
Multi-lane successor to the single-lane unsat clause selector. Each cycle it picks one clause index per lane as sel = R mod m, where R is a field taken from a random word and m is that lane's unsat buffer count. It computes this with a shared loadable reciprocal (1/m) table and a quotient-correction stage, so the result is exact rather than reciprocal-rounded. The block sits between the unsat clause buffers and the variable-flip pick logic, with valid/ready on both sides.

Parameters:
BUFFER_DEPTH, 2048, maximum unsat buffer occupancy; the table holds BUFFER_DEPTH+1 entries, indices 0..BUFFER_DEPTH.
NUM_LANES, 4, number of independent selection lanes.
RANDOM_OFFSET, 10, LSB position of R within each lane's 32-bit random word.
RANDOM_NUM_WIDTH, 18, width of R; must be strictly less than M_TABLE_WIDTH.
M_TABLE_WIDTH, 32, reciprocal entry width; entry[m] = floor((2^M_TABLE_WIDTH - 1)/m).
Derived: AW = clog2(BUFFER_DEPTH); CW = AW+1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
setup  in  1  table load mode
mt_we_i  in  1  table write strobe, honoured only while setup=1
write_addr_i  in  CW  table write address
mt_data_i  in  M_TABLE_WIDTH  table write data
ready  out  1  table loaded and block in RUN
req_valid_i  in  1  request valid; all lanes travel together
req_ready_o  out  1  request accepted when valid and ready are both 1
count_i  in  NUM_LANES*CW  per-lane m, lane k at [k*CW +: CW]
random_i  in  NUM_LANES*32  per-lane random word
sel_valid_o  out  1  result valid
sel_ready_i  in  1  downstream ready
sel_o  out  NUM_LANES*AW  per-lane selected index
sel_empty_o  out  NUM_LANES  per-lane flag: count was 0

Behaviour:
- Clock is clk; reset is synchronous and active-high. Single clock domain.
- Reset clears all pipeline valids. Output reset values: sel_valid_o=0, sel_o=0, sel_empty_o=0, req_ready_o=0.
- Reset does not clear the table or the loaded_q flag. loaded_q powers up 0.
- State machine, states LOAD and RUN:
  - After reset: RUN if loaded_q=1, otherwise LOAD.
  - LOAD: ready=0, req_ready_o=0. A write happens when setup=1 and mt_we_i=1. When setup falls, loaded_q is set and the state goes to RUN.
  - RUN: ready=1. If setup=1, all pipeline valids flush the same cycle, ready drops and the state goes to LOAD.
- Pipeline: three stages, one shared advance enable en = !sel_valid_o || sel_ready_i.
  - req_ready_o = en && state==RUN.
  - S1: capture m and R = random_i[RANDOM_OFFSET +: RANDOM_NUM_WIDTH]; read entry[m] (one table read port per lane).
  - S2: P = R*entry (RANDOM_NUM_WIDTH+M_TABLE_WIDTH bits); q = P >> M_TABLE_WIDTH.
  - S3: r = R - q*m, computed in RANDOM_NUM_WIDTH+1 bits; if r >= m then r = r - m. At most one correction is ever needed.
- Latency: an accepted request appears on sel_o exactly 3 cycles later when sel_ready_i stays high. Throughput is 1 request per cycle.
- Backpressure: when sel_valid_o=1 and sel_ready_i=0, all stages and outputs hold stable and no new request is taken.
- m=0: sel_o lane = 0, sel_empty_o lane = 1. Table entry 0 is don't-care.
- m=1: result is 0. m=BUFFER_DEPTH is legal.
- Table write and a read of the same address cannot coincide, because reads happen only in RUN.

Optional Feature:
CLAUSE_SEL_STATS_EN.
- Defined: adds outputs stat_sel_cnt_o[31:0] and stat_empty_cnt_o[31:0].
  - stat_sel_cnt_o counts output handshakes (sel_valid_o && sel_ready_i).
  - stat_empty_cnt_o adds, at each handshake, the popcount of sel_empty_o.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load the full table (entry[7]=0x24924924). Lane0 m=7, random_i=12345<<10 -> R=12345 -> sel_o lane0=4, valid 3 cycles after acceptance.
- Lanes m={1,10,2048,0}, R={99, 12345, 262143, 5} -> sel={0, 5, 2047, 0}, sel_empty_o=4'b1000.
- Stream 30 random requests back-to-back with sel_ready_i=1 -> every lane result equals R % m exactly (no rounding failures), one result per cycle.
- Hold sel_ready_i=0 for 5 cycles with the pipe full -> req_ready_o=0, sel_o stable; release -> no loss or duplication, order preserved.
- Assert reset mid-stream after a load -> sel_valid_o=0 the next cycle and ready=1 (table kept); the next request for m=7, R=12345 still gives 4.
- Power-up, then reset without setup -> ready=0, req_ready_o=0. Raise setup during RUN -> valids flush and ready=0 until setup falls.
